aes_key_schedule_seq: RTL
=========================

Name: aes_key_schedule_seq

Overview:
Sequential, word-serial AES key expansion engine supporting 128-, 192- and 256-bit keys, with the key length selected per job. It generates one 32-bit schedule word per cycle using a single 4-byte S-box path. It emits each 128-bit round key over a valid/ready stream to the round datapath. It supersedes the single-step combinational 256-bit evolve logic: one engine serves all key sizes and handles backpressure.

Parameters:
MAX_KEY_BITS, 256, largest key length accepted (128, 192 or 256); a requested key_len above this raises err.
RCON_INIT, 8'h01, first round constant; each later round constant = xtime(previous), i.e. shift left, XOR 8'h1b on carry-out.

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  asynchronous active-low reset
start  in  1  one-cycle job request; sampled only while busy=0
key_len  in  2  2'b00=128, 2'b01=192, 2'b10=256, 2'b11=illegal
key_in  in  256  cipher key, left-justified; w0=key_in[255:224]; unused low bits ignored
abort  in  1  synchronous job cancel
rk_data  out  128  round key {w4k, w4k+1, w4k+2, w4k+3}; w4k occupies [127:96]
rk_idx  out  4  round-key index k, 0..Nr
rk_valid  out  1  rk_data/rk_idx valid
rk_ready  in  1  consumer accept
busy  out  1  job in progress
done  out  1  one-cycle pulse after the last round key transfers
err  out  1  one-cycle pulse on a rejected start

Behaviour:
- Reset (n_rst=0, asynchronous): all outputs 0, FSM=IDLE, window/accumulator/Rcon cleared; takes effect mid-job with no done pulse.
- Nk = 4/6/8 and Nr = 10/12/14 for key_len 00/01/10; total words W = 4*(Nr+1) = 44/52/60.
- FSM states: IDLE, GEN, HOLD, FIN.
- IDLE: start=1 with legal key_len <= MAX_KEY_BITS → latch key, Nk, Rcon=RCON_INIT, i=0; go to GEN; busy=1 from the next edge.
- IDLE, start=1 with illegal or oversized key_len → err=1 for one cycle; stay IDLE.
- start while busy=1 is ignored.
- GEN: one word w[i] per cycle.
  - i<Nk: w[i] = latched key word i.
  - i mod Nk = 0: w[i] = w[i-Nk] ^ SubWord(RotWord(w[i-1])) ^ {Rcon,24'h0}; Rcon advances afterwards.
  - Nk=8 and i mod 8 = 4: w[i] = w[i-Nk] ^ SubWord(w[i-1]).
  - otherwise: w[i] = w[i-Nk] ^ w[i-1].
  - RotWord = {b[23:0], b[31:24]}.
  - History is an 8-word shift window; only the last Nk entries are used.
- Every 4th word (i mod 4 = 3): load rk_data and rk_idx=i/4; rk_valid=1 from the next edge.
- Stall rule: while rk_valid=1 and rk_ready=0, go to HOLD. Word generation freezes and rk_data/rk_idx stay stable.
- Transfer: rk_valid & rk_ready on an edge. With rk_ready=1, generation never stalls and one round key is presented every 4 cycles.
- Timing: start sampled at edge T → w0..w3 produced on edges T+1..T+4 → rk 0 valid after edge T+4.
- FIN: entered on transfer of rk_idx=Nr; rk_valid→0, done=1 for one cycle, busy→0, return to IDLE. A new start is accepted in the cycle after done.
- abort=1 in any non-IDLE state → IDLE at the next edge. rk_valid, busy→0; no done. abort has priority over a simultaneous transfer. abort in IDLE has no effect.
- The Rcon sequence for one job runs 01,02,04,08,10,20,40,80,1b,36; no wrap within a legal job.

Test Plan:
1. 128-bit key 2b7e1516 28aed2a6 abf71588 09cf4f3c, rk_ready=1 → rk0 = key; rk1[127:96]=a0fafe17; rk10 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6; done exactly 44 cycles after rk0 valid rose minus 3.
2. 192-bit key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b → w6=fe0c91f7 (rk1[63:32]); rk12 = e98ba06f 448c773c 8ecc7204 01002202; 13 round keys transferred.
3. 256-bit key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4 → w8=9ba35411, w12=a8b09c1a (SubWord-only branch); rk14 = fe4890d1 e6188d0b 046df344 706c631e.
4. 256-bit run with random rk_ready gaps (including 20-cycle holds) → rk_data/rk_idx stable while stalled; sequence identical to scenario 3; no index skipped or repeated.
5. key_len=2'b11, and key_len=2'b10 with MAX_KEY_BITS=128 → err pulse, busy stays 0, no rk_valid. start during busy → ignored, output unchanged.
6. abort asserted at rk_idx=5 with rk_valid=1 and rk_ready=1 → IDLE next cycle, no transfer counted, no done. n_rst pulsed mid-GEN → all outputs 0 immediately. The following 128-bit job matches scenario 1.

Source files
------------

// File: rtl/aes_key_schedule_seq.sv
// aes_key_schedule_seq
// Word-serial AES key expansion for 128/192/256-bit keys. The engine produces one
// 32-bit schedule word per cycle through a single 4-byte S-box path. Every fourth
// word completes a 128-bit round key, which is offered on a valid/ready stream.
//
// Ports:
//   clk, n_rst         clock (rising edge), asynchronous active-low reset
//   start, key_len     job request (taken only while busy=0), key size 00/01/10
//   key_in             left-justified cipher key, w0 = key_in[255:224]
//   abort              synchronous job cancel (no done pulse)
//   rk_data, rk_idx    round key {w4k..w4k+3} and its index k
//   rk_valid, rk_ready round-key stream handshake
//   busy, done, err    job active, end-of-job pulse, rejected-start pulse
//
// Handshake: a round key transfers on a rising edge where rk_valid=1 and rk_ready=1.
// Once rk_valid is raised, rk_data/rk_idx hold steady until that transfer (or an
// abort/reset). Word generation pauses while an offered key is not accepted.
module aes_key_schedule_seq #(
   parameter int         MAX_KEY_BITS = 256,
   parameter logic [7:0] RCON_INIT    = 8'h01
) (
   input  logic         clk,
   input  logic         n_rst,
   input  logic         start,
   input  logic [1:0]   key_len,
   input  logic [255:0] key_in,
   input  logic         abort,
   output logic [127:0] rk_data,
   output logic [3:0]   rk_idx,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic         busy,
   output logic         done,
   output logic         err
);

   typedef enum logic [1:0] {IDLE = 2'd0, GEN = 2'd1, HOLD = 2'd2, FIN = 2'd3} state_t;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
   endfunction

   state_t         state_q, state_d;
   logic [255:0]   key_q;
   logic [3:0]     nk_q;        // words per key: 4/6/8
   logic [3:0]     nr_q;        // last round-key index: 10/12/14
   logic [5:0]     i_q;         // index of the next schedule word
   logic [2:0]     cnt_q;       // i_q mod nk_q, kept as a counter since nk=6 is not a power of two
   logic [7:0]     rcon_q;
   logic [31:0]    win_q [8];   // win_q[0] = w[i-1], win_q[j] = w[i-1-j]
   logic [127:0]   rk_data_q;
   logic [3:0]     rk_idx_q;
   logic           rk_valid_q;
   logic           err_q;

   logic           legal, accept, reject, xfer, stall, last_xfer, gen_en, words_done;
   logic [2:0]     old_sel;
   logic [31:0]    key_w [8];
   logic [31:0]    prev_w, sub_in, sub_out, w_new;

   assign rk_data  = rk_data_q;
   assign rk_idx   = rk_idx_q;
   assign rk_valid = rk_valid_q;
   assign err      = err_q;

   always_comb begin
      legal = 1'b0;
      case (key_len)
         2'b00:   legal = (MAX_KEY_BITS >= 128);
         2'b01:   legal = (MAX_KEY_BITS >= 192);
         2'b10:   legal = (MAX_KEY_BITS >= 256);
         default: legal = 1'b0;
      endcase
   end

   assign accept     = (state_q == IDLE) && start && legal;
   assign reject     = (state_q == IDLE) && start && !legal;
   assign xfer       = rk_valid_q && rk_ready;
   assign stall      = rk_valid_q && !rk_ready;
   assign last_xfer  = xfer && (rk_idx_q == nr_q);
   assign words_done = (i_q > {nr_q, 2'b11});
   assign gen_en     = (state_q == GEN) && !abort && !stall && !words_done;
   // nk=8 wraps to 0 in three bits, so minus one lands on 7 as required.
   assign old_sel    = 3'(nk_q - 4'd1);

   // Next-state and status outputs.
   always_comb begin
      state_d = state_q;
      busy    = (state_q != IDLE);
      done    = (state_q == FIN);
      case (state_q)
         IDLE: if (accept) state_d = GEN;
         GEN: begin
            if (abort)          state_d = IDLE;
            else if (last_xfer) state_d = FIN;
            else if (stall)     state_d = HOLD;
         end
         HOLD: begin
            if (abort)          state_d = IDLE;
            else if (last_xfer) state_d = FIN;
            else if (xfer)      state_d = GEN;
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Next schedule word from the latched key or the history window.
   always_comb begin
      for (int j = 0; j < 8; j++) key_w[j] = key_q[255 - 32*j -: 32];
      prev_w  = win_q[0];
      sub_in  = (cnt_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
      sub_out = sub_word(sub_in);
      if (i_q < {2'b00, nk_q})
         w_new = key_w[i_q[2:0]];
      else if (cnt_q == 3'd0)
         w_new = win_q[old_sel] ^ sub_out ^ {rcon_q, 24'h0};
      else if ((nk_q == 4'd8) && (cnt_q == 3'd4))
         w_new = win_q[old_sel] ^ sub_out;
      else
         w_new = win_q[old_sel] ^ prev_w;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         key_q      <= '0;
         nk_q       <= '0;
         nr_q       <= '0;
         i_q        <= '0;
         cnt_q      <= '0;
         rcon_q     <= '0;
         for (int j = 0; j < 8; j++) win_q[j] <= '0;
         rk_data_q  <= '0;
         rk_idx_q   <= '0;
         rk_valid_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         err_q <= reject;
         if (accept) begin
            key_q  <= key_in;
            rcon_q <= RCON_INIT;
            i_q    <= '0;
            cnt_q  <= '0;
            case (key_len)
               2'b00:   begin nk_q <= 4'd4; nr_q <= 4'd10; end
               2'b01:   begin nk_q <= 4'd6; nr_q <= 4'd12; end
               default: begin nk_q <= 4'd8; nr_q <= 4'd14; end
            endcase
         end
         if (abort && (state_q != IDLE)) begin
            rk_valid_q <= 1'b0;
         end else begin
            if (xfer) rk_valid_q <= 1'b0;
            if (gen_en) begin
               win_q[0] <= w_new;
               for (int j = 1; j < 8; j++) win_q[j] <= win_q[j-1];
               i_q   <= i_q + 6'd1;
               cnt_q <= ({1'b0, cnt_q} == nk_q - 4'd1) ? 3'd0 : cnt_q + 3'd1;
               // Rcon is consumed by the word just generated; advance to xtime(rcon).
               if ((cnt_q == 3'd0) && (i_q >= {2'b00, nk_q}))
                  rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
               if (i_q[1:0] == 2'b11) begin
                  rk_data_q  <= {win_q[2], win_q[1], win_q[0], w_new};
                  rk_idx_q   <= i_q[5:2];
                  rk_valid_q <= 1'b1;
               end
            end
         end
      end
   end

endmodule
